// File: rtl/output_collector.sv
// Receive end of the systolic array: de-skews column-staggered results into
// whole rows and buffers them in a FWFT FIFO with a valid/ready read port.
module output_collector #(
    parameter int COLS   = 4,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COLS-1:0]            i_valid,
    input  logic [COLS*DWIDTH-1:0]     i_data,
    output logic                       i_ready,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [COLS*DWIDTH-1:0]     o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       overflow,
    output logic                       proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (COLS > 1) ? COLS - 1 : 1;

    logic [CW-1:0]     reserved_q, reserved_d;
    logic [CW-1:0]     committed_q, committed_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q [COLS];
    logic [PW-1:0]     pipe_q, pipe_d;
    logic              overflow_q, overflow_d;
    logic              proto_err_q, proto_err_d;
    logic [DWIDTH-1:0] mem_q [COLS][DEPTH];

    logic              full, acc0, commit, rd;
    logic [COLS-1:0]   lane_acc;

    always_comb begin
        full     = (reserved_q == CW'(DEPTH));
        acc0     = i_valid[0] & ~full;
        // lane j owns a slot exactly when lane 0 was accepted j cycles earlier
        lane_acc    = '0;
        lane_acc[0] = acc0;
        for (int unsigned j = 1; j < COLS; j++) begin
            lane_acc[j] = pipe_q[j-1];
        end
        commit = lane_acc[COLS-1];
        rd     = (committed_q != '0) & o_ready;

        pipe_d    = '0;
        pipe_d[0] = acc0;
        for (int unsigned j = 1; j < PW; j++) begin
            pipe_d[j] = pipe_q[j-1];
        end

        proto_err_d = proto_err_q;
        for (int unsigned j = 1; j < COLS; j++) begin
            if (lane_acc[j] && !i_valid[j]) begin
                proto_err_d = 1'b1;
            end
        end
        overflow_d  = overflow_q | (i_valid[0] & full);
        reserved_d  = reserved_q + CW'(acc0) - CW'(rd);
        committed_d = committed_q + CW'(commit) - CW'(rd);
        rd_ptr_d    = rd_ptr_q + AW'(rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reserved_q  <= '0;
            committed_q <= '0;
            rd_ptr_q    <= '0;
            pipe_q      <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            for (int unsigned j = 0; j < COLS; j++) begin
                wr_ptr_q[j] <= '0;
            end
        end else begin
            reserved_q  <= reserved_d;
            committed_q <= committed_d;
            rd_ptr_q    <= rd_ptr_d;
            pipe_q      <= pipe_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            // a missing beat still consumes its slot so lanes stay row-aligned
            for (int unsigned j = 0; j < COLS; j++) begin
                if (lane_acc[j]) begin
                    wr_ptr_q[j] <= wr_ptr_q[j] + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < COLS; j++) begin
            if (!rst && lane_acc[j] && i_valid[j]) begin
                mem_q[j][wr_ptr_q[j]] <= i_data[j*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        o_data = '0;
        for (int unsigned j = 0; j < COLS; j++) begin
            o_data[j*DWIDTH +: DWIDTH] = mem_q[j][rd_ptr_q];
        end
    end

    assign i_ready   = ~full;
    assign o_valid   = (committed_q != '0);
    assign o_count   = committed_q;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

endmodule
